// File: rtl/acc_sha256_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// acc_sha256_round_ctrl_if
// Bundle of the round controller's command, data-mover and worker strobes.
//   slave  : controller view (command/handshake in, strobes out)
//   master : environment view (command FSM, data mover, stall source)
// Signals:
//   start, num_blocks, abort  job command from the accelerator FSM
//   stall                     freezes round progress
//   blk_req / blk_valid       block fetch handshake with the data mover
//   ms_init, ms_enable        message scheduler load / advance
//   comp_init, iv_sel,        compression load, IV select, advance
//   comp_enable, round_idx
//   comp_accum                digest accumulate strobe
//   blk_idx, busy, done       job progress / status
// ---------------------------------------------------------------------------
interface acc_sha256_round_ctrl_if #(
   parameter int RND_W = 6,
   parameter int BLK_W = 8
);
   logic             start;
   logic [BLK_W-1:0] num_blocks;
   logic             abort;
   logic             stall;
   logic             blk_req;
   logic             blk_valid;
   logic             ms_init;
   logic             ms_enable;
   logic             comp_init;
   logic             iv_sel;
   logic             comp_enable;
   logic [RND_W-1:0] round_idx;
   logic             comp_accum;
   logic [BLK_W-1:0] blk_idx;
   logic             busy;
   logic             done;

   modport slave (
      input  start, num_blocks, abort, stall, blk_valid,
      output blk_req, ms_init, ms_enable, comp_init, iv_sel, comp_enable,
             round_idx, comp_accum, blk_idx, busy, done
   );

   modport master (
      output start, num_blocks, abort, stall, blk_valid,
      input  blk_req, ms_init, ms_enable, comp_init, iv_sel, comp_enable,
             round_idx, comp_accum, blk_idx, busy, done
   );
endinterface

// File: rtl/acc_sha256_round_ctrl.sv
// ---------------------------------------------------------------------------
// acc_sha256_round_ctrl
// Sequences one SHA256 job over N 512-bit blocks: per block it fetches the
// block, loads scheduler and compression state, runs ROUNDS lockstep rounds
// and then strobes digest accumulation.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   io_bus  controller side (slave modport) of acc_sha256_round_ctrl_if
// All strobes are decoded from the state register, except the round enables
// which also depend on the live stall input.
// ---------------------------------------------------------------------------
module acc_sha256_round_ctrl #(
   parameter int ROUNDS = 64,
   parameter int RND_W  = 6,
   parameter int BLK_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   acc_sha256_round_ctrl_if.slave  io_bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_ROUND = 3'd3;
   localparam logic [2:0] S_ACCUM = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

   logic [2:0]       r_state;
   logic [2:0]       w_nxt;
   logic [RND_W-1:0] r_round;
   logic [BLK_W-1:0] r_blk;
   logic [BLK_W-1:0] r_nblk;

   logic w_rnd_en;
   logic w_last_rnd;
   logic w_last_blk;
   logic w_accept;

   assign w_rnd_en   = (r_state == S_ROUND) && !io_bus.stall;
   assign w_last_rnd = (r_round == LAST_RND);
   assign w_last_blk = (r_blk == (r_nblk - BLK_W'(1)));
   // start is only honoured in IDLE and loses to a same-cycle abort
   assign w_accept   = (r_state == S_IDLE) && io_bus.start && !io_bus.abort;

   always_comb begin
      w_nxt = r_state;
      if (io_bus.abort) begin
         w_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (io_bus.start)
                        w_nxt = (io_bus.num_blocks == '0) ? S_DONE : S_FETCH;
            S_FETCH: if (io_bus.blk_valid) w_nxt = S_LOAD;
            S_LOAD:  w_nxt = S_ROUND;
            // leave only after the last round has actually been enabled
            S_ROUND: if (w_rnd_en && w_last_rnd) w_nxt = S_ACCUM;
            S_ACCUM: w_nxt = w_last_blk ? S_DONE : S_FETCH;
            S_DONE:  w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_round <= '0;
         r_blk   <= '0;
         r_nblk  <= '0;
      end else begin
         r_state <= w_nxt;
         if (w_accept) begin
            r_nblk <= io_bus.num_blocks;
            r_blk  <= '0;
         end else if (r_state == S_ACCUM && !io_bus.abort && !w_last_blk) begin
            r_blk <= r_blk + BLK_W'(1);
         end
         // round counter saturates at the last round and restarts only in LOAD
         if (r_state == S_LOAD && !io_bus.abort)
            r_round <= '0;
         else if (w_rnd_en && !w_last_rnd)
            r_round <= r_round + RND_W'(1);
      end
   end

   assign io_bus.blk_req     = (r_state == S_FETCH);
   assign io_bus.ms_init     = (r_state == S_LOAD);
   assign io_bus.comp_init   = (r_state == S_LOAD);
   assign io_bus.iv_sel      = (r_state == S_LOAD) && (r_blk == '0);
   assign io_bus.ms_enable   = w_rnd_en;
   assign io_bus.comp_enable = w_rnd_en;
   assign io_bus.round_idx   = r_round;
   assign io_bus.comp_accum  = (r_state == S_ACCUM);
   assign io_bus.blk_idx     = r_blk;
   assign io_bus.busy        = (r_state != S_IDLE);
   assign io_bus.done        = (r_state == S_DONE);

endmodule

// File: tb/tb_acc_sha256_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_acc_sha256_round_ctrl
// Scoreboard bench: each directed job pushes its expected LOAD / ACCUM / DONE
// events; a monitor pops and compares them as the strobes appear.
// Event aux field: LOAD = blk_req cycles seen, ACCUM = enabled rounds,
// DONE = cycle index counted from the start edge (edge 0 -> cycle 1).
// ---------------------------------------------------------------------------
module tb_acc_sha256_round_ctrl;
   localparam int ROUNDS = 64;
   localparam int RND_W  = 6;
   localparam int BLK_W  = 8;

   localparam int EV_LOAD = 0;
   localparam int EV_ACC  = 1;
   localparam int EV_DONE = 2;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   acc_sha256_round_ctrl_if #(.RND_W(RND_W), .BLK_W(BLK_W)) bus ();

   acc_sha256_round_ctrl #(.ROUNDS(ROUNDS), .RND_W(RND_W), .BLK_W(BLK_W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   typedef struct {
      int kind;
      int blk;
      int iv;
      int aux;
   } ev_t;

   ev_t sb[$];
   int  n_cmp   = 0;
   int  n_bad   = 0;
   int  cyc     = 0;
   int  t_start = 0;
   int  vdly    = 0;
   bit  stall_en = 1'b0;
   int  rcnt    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic push(input int k, input int b, input int iv, input int aux);
      ev_t e;
      e.kind = k; e.blk = b; e.iv = iv; e.aux = aux;
      sb.push_back(e);
   endtask

   task automatic got(input ev_t o);
      ev_t e;
      chk("sb_expect_present", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("ev_kind", o.kind, e.kind);
         chk("ev_blk_idx", o.blk, e.blk);
         chk("ev_iv_sel", o.iv, e.iv);
         chk("ev_aux", o.aux, e.aux);
      end
   endtask

   // data mover: blk_valid rises in the vdly-th cycle of blk_req (0 = held high)
   always @(negedge clk) begin
      if (bus.blk_req) begin
         rcnt          <= rcnt + 1;
         bus.blk_valid <= (rcnt + 1 >= vdly);
      end else begin
         rcnt          <= 0;
         bus.blk_valid <= (vdly == 0);
      end
   end

   // stall source: one stalled cycle each at rounds 10, 11 and 63
   initial begin : stall_drv
      bit m10, m11, m63;
      m10 = 0; m11 = 0; m63 = 0;
      bus.stall = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!stall_en) begin
            bus.stall = 1'b0;
         end else if (bus.ms_init) begin
            m10 = 0; m11 = 0; m63 = 0;
            bus.stall = 1'b0;
         end else if (bus.round_idx == 6'd10 && !m10) begin
            m10 = 1; bus.stall = 1'b1;
         end else if (bus.round_idx == 6'd11 && !m11) begin
            m11 = 1; bus.stall = 1'b1;
         end else if (bus.round_idx == 6'd63 && !m63) begin
            m63 = 1; bus.stall = 1'b1;
         end else begin
            bus.stall = 1'b0;
         end
      end
   end

   // monitor
   initial begin : mon
      int  en_cnt, req_seen;
      ev_t o;
      en_cnt = 0; req_seen = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            en_cnt = 0; req_seen = 0;
         end else begin
            chk("en_lockstep", int'(bus.ms_enable), int'(bus.comp_enable));
            chk("init_lockstep", int'(bus.ms_init), int'(bus.comp_init));
            chk("strobe_excl", int'($countones({bus.ms_init, bus.comp_accum, bus.done}) <= 1), 1);
            chk("init_vs_enable", int'(bus.ms_enable & bus.ms_init), 0);
            chk("iv_outside_load", int'(bus.iv_sel & ~bus.ms_init), 0);
            if (bus.blk_req) req_seen++;
            if (bus.ms_enable) begin
               chk("round_idx", int'(bus.round_idx), en_cnt);
               en_cnt++;
            end
            if (bus.ms_init) begin
               o.kind = EV_LOAD; o.blk = int'(bus.blk_idx); o.iv = int'(bus.iv_sel); o.aux = req_seen;
               got(o);
               req_seen = 0; en_cnt = 0;
            end
            if (bus.comp_accum) begin
               o.kind = EV_ACC; o.blk = int'(bus.blk_idx); o.iv = int'(bus.iv_sel); o.aux = en_cnt;
               got(o);
            end
            if (bus.done) begin
               o.kind = EV_DONE; o.blk = 0; o.iv = int'(bus.iv_sel); o.aux = cyc - t_start;
               got(o);
            end
         end
      end
   end

   task automatic go(input int n);
      bus.start      = 1'b1;
      bus.num_blocks = BLK_W'(n);
      t_start        = cyc;
      @(negedge clk);
      bus.start      = 1'b0;
      bus.num_blocks = 8'hA5;   // ignored while busy
   endtask

   task automatic drain(input string nm, input int lim);
      int n;
      n = 0;
      while (sb.size() != 0 && n < lim) begin
         @(posedge clk);
         n++;
      end
      chk(nm, sb.size(), 0);
      sb.delete();
      @(negedge clk);
   endtask

   task automatic wait_round(input int r);
      int n;
      n = 0;
      while (!(bus.ms_enable && int'(bus.round_idx) == r) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("wait_round_reached", int'(bus.ms_enable && int'(bus.round_idx) == r), 1);
   endtask

   initial begin
      bus.start = 1'b0; bus.num_blocks = '0; bus.abort = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_blk_req", bus.blk_req, 0);
      chk("rst_ms_init", bus.ms_init, 0);
      chk("rst_round_idx", int'(bus.round_idx), 0);
      chk("rst_blk_idx", int'(bus.blk_idx), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // single block, blk_valid held
      vdly = 0;
      push(EV_LOAD, 0, 1, 1); push(EV_ACC, 0, 0, 64); push(EV_DONE, 0, 0, 68);
      go(1);
      drain("single_drain", 200);
      chk("single_idle_busy", bus.busy, 0);
      chk("single_round_hold", int'(bus.round_idx), 63);

      // three blocks, blk_valid after 5 request cycles
      vdly = 5;
      push(EV_LOAD, 0, 1, 5); push(EV_ACC, 0, 0, 64);
      push(EV_LOAD, 1, 0, 5); push(EV_ACC, 1, 0, 64);
      push(EV_LOAD, 2, 0, 5); push(EV_ACC, 2, 0, 64);
      push(EV_DONE, 0, 0, 214);
      go(3);
      drain("three_drain", 400);
      chk("three_idle_busy", bus.busy, 0);
      vdly = 0;

      // stalls at rounds 10, 11, 63 add three cycles
      stall_en = 1'b1;
      push(EV_LOAD, 0, 1, 1); push(EV_ACC, 0, 0, 64); push(EV_DONE, 0, 0, 71);
      go(1);
      drain("stall_drain", 200);
      stall_en = 1'b0;

      // abort at round 30 of the first of two blocks
      push(EV_LOAD, 0, 1, 1);
      go(2);
      wait_round(30);
      bus.abort = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      bus.start = 1'b0;
      chk("abort_busy", bus.busy, 0);
      chk("abort_ms_enable", bus.ms_enable, 0);
      chk("abort_blk_req", bus.blk_req, 0);
      repeat (4) @(negedge clk);
      chk("abort_no_more_events", sb.size(), 0);
      chk("abort_still_idle", bus.busy, 0);

      // abort in IDLE wins over start
      bus.abort = 1'b1; bus.start = 1'b1; bus.num_blocks = 8'd1;
      @(negedge clk);
      bus.abort = 1'b0; bus.start = 1'b0;
      chk("abort_start_ignored", bus.busy, 0);

      // a fresh job completes normally
      push(EV_LOAD, 0, 1, 1); push(EV_ACC, 0, 0, 64); push(EV_DONE, 0, 0, 68);
      go(1);
      drain("restart_drain", 200);

      // zero blocks: done in the cycle after start
      push(EV_DONE, 0, 0, 1);
      go(0);
      chk("nb0_busy", bus.busy, 1);
      chk("nb0_blk_req", bus.blk_req, 0);
      chk("nb0_ms_init", bus.ms_init, 0);
      drain("nb0_drain", 10);
      chk("nb0_idle", bus.busy, 0);

      // asynchronous reset mid-ROUND
      push(EV_LOAD, 0, 1, 1);
      go(1);
      wait_round(20);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", bus.busy, 0);
      chk("arst_ms_enable", bus.ms_enable, 0);
      chk("arst_comp_enable", bus.comp_enable, 0);
      chk("arst_round_idx", int'(bus.round_idx), 0);
      chk("arst_blk_idx", int'(bus.blk_idx), 0);
      bus.start = 1'b1; bus.num_blocks = 8'd1;
      repeat (3) begin
         @(negedge clk);
         chk("arst_start_ignored", bus.busy, 0);
         chk("arst_done_low", bus.done, 0);
      end
      bus.start = 1'b0;
      chk("arst_sb_empty", sb.size(), 0);
      sb.delete();
      rst_n = 1'b1;
      @(negedge clk);
      chk("arst_release_idle", bus.busy, 0);
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
